// File: rtl/run_length_detector_if.sv
// ---------------------------------------------------------------------------
// run_length_detector_if
// Groups the serial input, its qualifier, the mode select and the detector
// outputs into one bundle.
//   master : the side that feeds bits and reads the result (sampler/bench)
//   slave  : the detector itself
// Signals:
//   in_valid, in_bit, mode_pulse   master -> slave
//   z, run_val, run_cnt[CNT_W]     slave  -> master
//   sticky_clr / sticky            only when RLD_STICKY_EN is defined
// ---------------------------------------------------------------------------
interface run_length_detector_if #(
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_bit;
  logic             mode_pulse;
  logic             z;
  logic             run_val;
  logic [CNT_W-1:0] run_cnt;
`ifdef RLD_STICKY_EN
  logic             sticky;
  logic             sticky_clr;
`endif

  modport master (
    output in_valid,
    output in_bit,
    output mode_pulse,
`ifdef RLD_STICKY_EN
    output sticky_clr,
    input  sticky,
`endif
    input  z,
    input  run_val,
    input  run_cnt
  );

  modport slave (
    input  in_valid,
    input  in_bit,
    input  mode_pulse,
`ifdef RLD_STICKY_EN
    input  sticky_clr,
    output sticky,
`endif
    output z,
    output run_val,
    output run_cnt
  );
endinterface

// File: rtl/run_length_detector.sv
// ---------------------------------------------------------------------------
// run_length_detector
// Asserts z when the serial input has held the same value for RUN_LEN
// consecutive accepted bits (in_valid=1). Level mode keeps z high while the
// run lasts; pulse mode emits a one-cycle z every RUN_LEN matching bits.
// All outputs are registered; latency is one clock edge.
//
// Parameters:
//   RUN_LEN : identical bits needed for a hit, 2 <= RUN_LEN <= 2**CNT_W-1
//   CNT_W   : width of run_cnt (saturates at 2**CNT_W-1)
// Ports:
//   clk     : rising-edge clock
//   reset   : synchronous, active-high, clears all state
//   bus     : run_length_detector_if.slave (in_valid, in_bit, mode_pulse,
//             z, run_val, run_cnt [, sticky_clr, sticky])
// Optional feature:
//   RLD_STICKY_EN : adds a sticky hit flag (set by z, cleared by sticky_clr)
// ---------------------------------------------------------------------------
module run_length_detector #(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 4
) (
  input logic                   clk,
  input logic                   reset,
  run_length_detector_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  state_e           state_q,   state_d;
  logic             z_q,       z_d;
  logic             run_val_q, run_val_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
`ifdef RLD_STICKY_EN
  logic             sticky_q,  sticky_d;
`endif

  logic             match_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             pulse_hit_s;

  // Shared decode: saturating increment, run match and pulse-hit condition
  always_comb begin
    cnt_inc_s = (run_cnt_q == CNT_MAX) ? run_cnt_q : (run_cnt_q + CNT_ONE);
    // In IDLE there is no run yet, so any bit starts a new one
    match_s   = (state_q != ST_IDLE) && (bus.in_bit == run_val_q);
    // Coming from HIT (mode switched to pulse) the count is already past
    // RUN_LEN, so the next matching bit pulses immediately
    pulse_hit_s = (state_q == ST_HIT) || (cnt_inc_s == RUN_LEN_C);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      z_q       <= 1'b0;
      run_val_q <= 1'b0;
      run_cnt_q <= CNT_ZERO;
`ifdef RLD_STICKY_EN
      sticky_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      z_q       <= z_d;
      run_val_q <= run_val_d;
      run_cnt_q <= run_cnt_d;
`ifdef RLD_STICKY_EN
      sticky_q  <= sticky_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!bus.in_valid) begin
      state_d = state_q;
    end else if (!match_s) begin
      state_d = ST_RUN;
    end else if (bus.mode_pulse) begin
      state_d = ST_RUN;
    end else if (cnt_inc_s >= RUN_LEN_C) begin
      state_d = ST_HIT;
    end else begin
      state_d = ST_RUN;
    end
  end

  // Output/datapath next values
  always_comb begin
    z_d       = z_q;
    run_val_d = run_val_q;
    run_cnt_d = run_cnt_q;
    if (!bus.in_valid) begin
      // Only a level-mode hit keeps z high across an idle cycle; a pulse
      // is always left in ST_RUN, so this also ends any pulse after 1 cycle
      z_d = (state_q == ST_HIT);
    end else if (!match_s) begin
      run_val_d = bus.in_bit;
      run_cnt_d = CNT_ONE;
      z_d       = 1'b0;
    end else if (bus.mode_pulse) begin
      if (pulse_hit_s) begin
        z_d       = 1'b1;
        run_cnt_d = CNT_ZERO;
      end else begin
        z_d       = 1'b0;
        run_cnt_d = cnt_inc_s;
      end
    end else begin
      run_cnt_d = cnt_inc_s;
      z_d       = (cnt_inc_s >= RUN_LEN_C);
    end
`ifdef RLD_STICKY_EN
    // Set dominates clear when both happen on the same edge
    if (z_d) begin
      sticky_d = 1'b1;
    end else if (bus.sticky_clr) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
`endif
  end

  assign bus.z       = z_q;
  assign bus.run_val = run_val_q;
  assign bus.run_cnt = run_cnt_q;
`ifdef RLD_STICKY_EN
  assign bus.sticky  = sticky_q;
`endif

endmodule

// File: tb/tb_run_length_detector.sv
// ---------------------------------------------------------------------------
// tb_run_length_detector
// Directed bench for run_length_detector with RUN_LEN=4, CNT_W=4. Each step
// drives one cycle of inputs, pushes the expected outputs onto a scoreboard
// queue, and pops/compares them one edge later.
// ---------------------------------------------------------------------------
module tb_run_length_detector;

  typedef struct {
    logic       z;
    logic       v;
    logic [3:0] c;
    logic       s;
    string      tag;
  } exp_t;

  logic clk;
  logic reset;
  logic sclr;
  logic es;
  int   tests_cnt;
  int   fail_cnt;
  exp_t sb_q[$];

  run_length_detector_if #(.CNT_W(4)) bus ();

  run_length_detector #(.RUN_LEN(4), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus followed by the scoreboard comparison
  task automatic step(input logic r, input logic v, input logic b, input logic m,
                      input logic ez, input logic ev, input logic [3:0] ec,
                      input string tag);
    exp_t e;
    exp_t g;
    reset        = r;
    bus.in_valid = v;
    bus.in_bit   = b;
    bus.mode_pulse = m;
`ifdef RLD_STICKY_EN
    bus.sticky_clr = sclr;
`endif
    if (r) es = 1'b0;
    else if (ez) es = 1'b1;
    else if (sclr) es = 1'b0;
    else es = es;
    e.z = ez; e.v = ev; e.c = ec; e.s = es; e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    tests_cnt++;
    assert (bus.z === g.z) else begin
      fail_cnt++;
      $error("FAIL %s z: observed %0b expected %0b", g.tag, bus.z, g.z);
    end
    tests_cnt++;
    assert (bus.run_val === g.v) else begin
      fail_cnt++;
      $error("FAIL %s run_val: observed %0b expected %0b", g.tag, bus.run_val, g.v);
    end
    tests_cnt++;
    assert (bus.run_cnt === g.c) else begin
      fail_cnt++;
      $error("FAIL %s run_cnt: observed %0d expected %0d", g.tag, bus.run_cnt, g.c);
    end
`ifdef RLD_STICKY_EN
    tests_cnt++;
    assert (bus.sticky === g.s) else begin
      fail_cnt++;
      $error("FAIL %s sticky: observed %0b expected %0b", g.tag, bus.sticky, g.s);
    end
`endif
  endtask

  initial begin
    tests_cnt = 0;
    fail_cnt  = 0;
    sclr      = 1'b0;
    es        = 1'b0;
    reset     = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    bus.mode_pulse = 1'b0;
`ifdef RLD_STICKY_EN
    bus.sticky_clr = 1'b0;
`endif
    #2;
    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "rst0");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "idle_hold");

    // Level mode: four ones, a fifth, then a breaking zero
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, "t1_b1");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, "t1_b2");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, "t1_b3");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd4, "t1_b4");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd5, "t1_b5");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, "t1_break");

    // Level mode with a 5-cycle in_valid gap
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "t3_rst");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, "t3_b1");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, "t3_b2");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, "t3_b3");
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, $sformatf("t3_gap%0d", i));
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd4, "t3_resume");

    // Level mode 0,0,0,1,1,1,1 then run to saturation with 20 ones
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, "t4_z1");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, "t4_z2");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, "t4_z3");
    for (int i = 1; i <= 20; i++)
      step(1'b0, 1'b1, 1'b1, 1'b0, (i >= 4) ? 1'b1 : 1'b0, 1'b1,
           (i >= 15) ? 4'd15 : 4'(i), $sformatf("t4_o%0d", i));
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd15, "t4_sat_gap");

    // Reset on the same edge as an accepted bit while z is high
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "t5_rst_hit");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "t5_idle");

    // Pulse mode: eight zeros give two single-cycle pulses
    for (int i = 1; i <= 8; i++)
      step(1'b0, 1'b1, 1'b0, 1'b1, (i % 4 == 0) ? 1'b1 : 1'b0, 1'b0,
           4'(i % 4), $sformatf("t2_b%0d", i));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, "t2_after");

    // Level hit, then switch to pulse mode while in HIT
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, "sw_b1");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, "sw_b2");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, "sw_b3");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd4, "sw_b4");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, "sw_pulse");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, "sw_next");

`ifdef RLD_STICKY_EN
    // Sticky flag: survives z dropping, set beats clear, later clear works
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "t6_rst");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, "t6_b1");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2, "t6_b2");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3, "t6_b3");
    sclr = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, "t6_set_vs_clr");
    sclr = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, "t6_persist");
    sclr = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, "t6_clear");
    sclr = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, "t6_stays_clr");
`endif

    $display("[TB] %0d tests run, %0d failed", tests_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/run_length_detector.md
# run_length_detector

- Parametrised synchronous detector that asserts `z` when the serial input holds the same value for `RUN_LEN` consecutive accepted bits.
- Generalises the fixed four-in-a-row ones/zeros detector used on the board switches: configurable run length, input qualifier, two output modes and an exposed run counter.
- Sits between the debounced key/switch sampler and the symbol classifier in the Morse transmitter path; it distinguishes dot/dash-length holds.

## Interface

Parameters:
- `RUN_LEN`, default 4: consecutive identical bits required for a hit. Legal range is 2 ≤ `RUN_LEN` ≤ 2^`CNT_W`−1.
- `CNT_W`, default 4: width of `run_cnt`.

Ports (`clk` and `reset` first). One clock; reset is synchronous and active-high.
- `clk`, input, 1: sole clock. Everything updates on the rising edge.
- `reset`, input, 1: synchronous, active-high. Clears all state.
- `in_valid`, input, 1: qualifies `in_bit`. A bit is accepted only on an edge where `in_valid`=1.
- `in_bit`, input, 1: serial data bit.
- `mode_pulse`, input, 1:
  - 0 = level mode: `z` stays high while the run continues.
  - 1 = pulse mode: one-cycle `z` per `RUN_LEN` bits, non-overlapping.
- `z`, output, 1: hit indication. Registered.
- `run_val`, output, 1: value of the current run. Registered.
- `run_cnt`, output, `CNT_W`: length of the current run, saturating. Registered.
- `sticky`, output, 1: present only with `RLD_STICKY_EN`.
- `sticky_clr`, input, 1: present only with `RLD_STICKY_EN`.

## Operation

- States:
  - `ST_IDLE`: no bit accepted since reset.
  - `ST_RUN`: `run_cnt` < `RUN_LEN`.
  - `ST_HIT`: level mode only, `run_cnt` ≥ `RUN_LEN`.
- Reset values: state=`ST_IDLE`, `z`=0, `run_val`=0, `run_cnt`=0, `sticky`=0.
- Reset has priority over every other input in the same cycle, including mid-run and mid-hit.
- Accepted bit `b` in `ST_IDLE`: `run_val`←`b`, `run_cnt`←1, go to `ST_RUN`.
- Accepted bit with `b`≠`run_val`: `run_val`←`b`, `run_cnt`←1, go to `ST_RUN`, `z`←0. This applies in `ST_RUN` and in `ST_HIT`.
- Accepted bit with `b`=`run_val`: `run_cnt`←min(`run_cnt`+1, 2^`CNT_W`−1).
  - Level mode, new count ≥ `RUN_LEN`: go to `ST_HIT`, `z`←1.
  - Pulse mode, new count = `RUN_LEN`: `z`←1 for one cycle, `run_cnt`←0, stay in `ST_RUN`, keep `run_val`. The next hit needs `RUN_LEN` further identical bits.
- `in_valid`=0 cycle:
  - State, `run_val` and `run_cnt` hold.
  - Level mode: `z` holds.
  - Pulse mode: `z`←0.
- `mode_pulse` is sampled only on accepted bits. Changing it never clears the count.
  - Switching to pulse mode while in `ST_HIT`: the next matching accepted bit emits a pulse, sets `run_cnt`←0 and moves to `ST_RUN`.
  - Switching to level mode: behaves per the level rules from the next accepted bit.
- `run_cnt` saturates at 2^`CNT_W`−1 and never wraps. `z` remains high in level mode while saturated.

## Timing

- Latency 1 edge. `z` rises in the cycle after the edge that accepted the `RUN_LEN`-th identical bit.
- `run_val` and `run_cnt` reflect the bit accepted on the previous edge.
- Pulse-mode `z` is exactly one `clk` cycle wide.
  - Back-to-back pulses are impossible; at least `RUN_LEN` accepted bits separate them.
- Level-mode `z` falls one edge after the accepted bit that breaks the run.
- No combinational path from inputs to outputs.

## Configuration

- Macro `RLD_STICKY_EN`.
- Defined:
  - Adds `sticky` and `sticky_clr`.
  - `sticky` sets on any edge where `z` is being set to 1.
  - `sticky` clears on `reset` or `sticky_clr`=1. Set wins over clear in the same cycle.
  - Output latency of `sticky` is the same as `z`.
- Undefined: both ports and the register are absent. All other behaviour is identical.

## Test plan

All scenarios use `RUN_LEN`=4, `CNT_W`=4.

1. Level mode, 1,1,1,1 accepted on consecutive edges → `z`=1 the cycle after the 4th bit. A 5th 1 → `run_cnt`=5, `z` stays 1. Then a 0 → `z`=0, `run_val`=0, `run_cnt`=1.
2. Pulse mode, eight consecutive 0s → `z` pulses exactly twice (after bits 4 and 8), each pulse one cycle wide. `run_cnt` reads 0 after bits 4 and 8.
3. Level mode, 1,1,1 then `in_valid`=0 for 5 cycles, then 1 → `run_cnt` holds 3 during the gap, then `z`=1 one cycle after the resumed bit.
4. Level mode, 0,0,0,1,1,1,1 → `z` stays 0 until after the 7th bit. Run with 20 identical bits → `run_cnt` saturates at 15, `z` stays 1.
5. `reset`=1 asserted while `z`=1 and `in_valid`=1 on the same edge → next cycle `z`=0, `run_cnt`=0, `run_val`=0, state `ST_IDLE`.
6. With `RLD_STICKY_EN`: pulse-mode hit → `sticky`=1 persists after `z` drops. `sticky_clr` held on the edge that sets `z` → `sticky`=1. `sticky_clr` on a later cycle → `sticky`=0.
